// File: rtl/axis_pkt_tx_if.sv
// -----------------------------------------------------------------------------
// axis_pkt_tx_if
// Bundles the command port and the AXI-Stream beat port of axis_pkt_tx.
// Signal names keep the transmitter's point of view (i_ = into the transmitter,
// o_ = out of the transmitter).
//   master modport : transmitter side (drives o_*, reads i_*)
//   slave  modport : environment side (drives i_*, reads o_*)
// Signals:
//   o_cmd_ready  command port ready
//   i_cmd_valid  command port valid
//   i_cmd_len    packet length minus one
//   i_cmd_seed   data value of the first beat
//   i_cmd_step   increment added per beat
//   i_ready      downstream ready
//   o_valid      stream valid
//   o_data       stream data
//   o_last       last beat of the packet
//   o_busy       packet in flight
// -----------------------------------------------------------------------------
interface axis_pkt_tx_if #(
  parameter int NB_DATA = 32,
  parameter int NB_LEN  = 16
);
  logic               o_cmd_ready;
  logic               i_cmd_valid;
  logic [NB_LEN-1:0]  i_cmd_len;
  logic [NB_DATA-1:0] i_cmd_seed;
  logic [NB_DATA-1:0] i_cmd_step;
  logic               i_ready;
  logic               o_valid;
  logic [NB_DATA-1:0] o_data;
  logic               o_last;
  logic               o_busy;

  modport master (
    output o_cmd_ready, o_valid, o_data, o_last, o_busy,
    input  i_cmd_valid, i_cmd_len, i_cmd_seed, i_cmd_step, i_ready
  );

  modport slave (
    input  o_cmd_ready, o_valid, o_data, o_last, o_busy,
    output i_cmd_valid, i_cmd_len, i_cmd_seed, i_cmd_step, i_ready
  );
endinterface

// File: rtl/axis_pkt_tx.sv
// -----------------------------------------------------------------------------
// axis_pkt_tx
// AXI-Stream packet transmitter. A command (length-1, seed, step) accepted on
// the command port produces one packet of len+1 beats whose data follows
// seed, seed+step, seed+2*step, ... (modulo 2^NB_DATA); the final beat carries
// o_last. All outputs are registered; there is no input-to-output
// combinational path.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   bus          axis_pkt_tx_if.master (command + stream signals)
//   o_stall_cnt  [31:0] saturating count of cycles with o_valid & !i_ready
//                (present only when AXIS_PKT_TX_STALL_CNT_EN is defined)
// Optional feature macro: AXIS_PKT_TX_STALL_CNT_EN
// -----------------------------------------------------------------------------
module axis_pkt_tx #(
  parameter int NB_DATA = 32,
  parameter int NB_LEN  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  axis_pkt_tx_if.master      bus
`ifdef AXIS_PKT_TX_STALL_CNT_EN
  ,
  output logic [31:0]        o_stall_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [NB_DATA-1:0] data_q,      data_d;
  logic [NB_DATA-1:0] step_q,      step_d;
  logic [NB_LEN-1:0]  rem_q,       rem_d;
  logic               valid_q,     valid_d;
  logic               last_q,      last_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q,      busy_d;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= {NB_DATA{1'b0}};
      step_q      <= {NB_DATA{1'b0}};
      rem_q       <= {NB_LEN{1'b0}};
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      step_q      <= step_d;
      rem_q       <= rem_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    step_d      = step_q;
    rem_d       = rem_q;
    valid_d     = valid_q;
    last_d      = last_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid && cmd_ready_q) begin
          step_d      = bus.i_cmd_step;
          rem_d       = bus.i_cmd_len;
          data_d      = bus.i_cmd_seed;
          valid_d     = 1'b1;
          last_d      = (bus.i_cmd_len == {NB_LEN{1'b0}});
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_SEND;
        end else begin
          valid_d     = 1'b0;
          last_d      = 1'b0;
        end
      end
      ST_SEND: begin
        if (valid_q && bus.i_ready) begin
          if (last_q) begin
            valid_d     = 1'b0;
            last_d      = 1'b0;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            // Counting remaining down from len means a full 2^NB_LEN-beat
            // packet never needs a wider counter.
            data_d = data_q + step_q;
            rem_d  = rem_q - NB_LEN'(1'b1);
            last_d = (rem_q == NB_LEN'(1'b1));
          end
        end else begin
          // Stall: hold the beat until it is accepted.
          valid_d = valid_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign bus.o_cmd_ready = cmd_ready_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_last      = last_q;
  assign bus.o_busy      = busy_q;

`ifdef AXIS_PKT_TX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating stall counter next value
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !bus.i_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_tx
// Self-checking bench for axis_pkt_tx. Inputs are driven and outputs sampled on
// the falling clock edge. Expected beats come from the closed form
// seed + k*step (mod 2^32) with last on k == len.
// -----------------------------------------------------------------------------
module tb_axis_pkt_tx;
  localparam int NB_DATA = 32;
  localparam int NB_LEN  = 16;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  always #5 i_clk = ~i_clk;

  axis_pkt_tx_if #(.NB_DATA(NB_DATA), .NB_LEN(NB_LEN)) bus ();

`ifdef AXIS_PKT_TX_STALL_CNT_EN
  logic [31:0] stall_cnt_s;
`endif

  axis_pkt_tx #(.NB_DATA(NB_DATA), .NB_LEN(NB_LEN)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
`ifdef AXIS_PKT_TX_STALL_CNT_EN
    ,
    .o_stall_cnt (stall_cnt_s)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  longint unsigned stall_exp = 0;

  // Command held on the port while the current packet is in flight
  logic        nxt_valid = 1'b0;
  int          nxt_len   = 0;
  logic [31:0] nxt_seed  = 32'd0;
  logic [31:0] nxt_step  = 32'd0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_beat(input logic [31:0] seed, input logic [31:0] step,
                                           input int unsigned k);
    logic [31:0] kk;
    kk = k;
    return seed + step * kk;
  endfunction

  task automatic drive_next_cmd();
    bus.i_cmd_valid = nxt_valid;
    if (nxt_valid) begin
      bus.i_cmd_len  = NB_LEN'(nxt_len);
      bus.i_cmd_seed = nxt_seed;
      bus.i_cmd_step = nxt_step;
    end else begin
      bus.i_cmd_len  = NB_LEN'($urandom);
      bus.i_cmd_seed = $urandom;
      bus.i_cmd_step = $urandom;
    end
  endtask

  task automatic check_stall();
`ifdef AXIS_PKT_TX_STALL_CNT_EN
    check_val("stall_cnt", {32'd0, stall_cnt_s}, stall_exp);
`endif
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // after the last beat was accepted.
  task automatic send_pkt(input int len, input logic [31:0] seed, input logic [31:0] step,
                          input int mode);
    int   k;
    int   it;
    int   bound;
    logic rdy;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_len   = NB_LEN'(len);
    bus.i_cmd_seed  = seed;
    bus.i_cmd_step  = step;
    bus.i_ready     = 1'($urandom_range(1, 0));
    check_val("cmd_ready_idle", {63'd0, bus.o_cmd_ready}, 64'd1);
    @(negedge i_clk);
    check_val("first_valid", {63'd0, bus.o_valid}, 64'd1);
    check_val("busy_send", {63'd0, bus.o_busy}, 64'd1);
    check_val("cmd_ready_send", {63'd0, bus.o_cmd_ready}, 64'd0);
    k = 0;
    it = 0;
    bound = (len + 1) * 32 + 100;
    while (k <= len && it < bound) begin
      check_val("beat_valid", {63'd0, bus.o_valid}, 64'd1);
      check_val("beat_data", {32'd0, bus.o_data}, {32'd0, exp_beat(seed, step, k)});
      check_val("beat_last", {63'd0, bus.o_last}, {63'd0, (k == len)});
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((it % 3) == 0);
        default: rdy = ($urandom_range(99, 0) < 60);
      endcase
      if (!rdy) stall_exp++;
      bus.i_ready = rdy;
      drive_next_cmd();
      @(negedge i_clk);
      if (rdy) k++;
      it++;
    end
    if (k <= len) begin
      check_val("beat_timeout", 64'(k), 64'(len + 1));
    end else begin
      check_val("bubble_valid", {63'd0, bus.o_valid}, 64'd0);
      check_val("bubble_last", {63'd0, bus.o_last}, 64'd0);
      check_val("bubble_cmd_ready", {63'd0, bus.o_cmd_ready}, 64'd1);
      check_val("bubble_busy", {63'd0, bus.o_busy}, 64'd0);
    end
    check_stall();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_len   = NB_LEN'($urandom);
      bus.i_cmd_seed  = $urandom;
      bus.i_ready     = 1'($urandom_range(1, 0));
      @(negedge i_clk);
      check_val("idle_valid", {63'd0, bus.o_valid}, 64'd0);
      check_val("idle_cmd_ready", {63'd0, bus.o_cmd_ready}, 64'd1);
      check_val("idle_busy", {63'd0, bus.o_busy}, 64'd0);
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_valid", {63'd0, bus.o_valid}, 64'd0);
    check_val("rst_last", {63'd0, bus.o_last}, 64'd0);
    check_val("rst_data", {32'd0, bus.o_data}, 64'd0);
    check_val("rst_busy", {63'd0, bus.o_busy}, 64'd0);
    check_val("rst_cmd_ready", {63'd0, bus.o_cmd_ready}, 64'd1);
    check_stall();
  endtask

  task automatic reset_mid_packet();
    logic [31:0] seed;
    logic [31:0] step;
    seed = $urandom;
    step = $urandom;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_len   = NB_LEN'(7);
    bus.i_cmd_seed  = seed;
    bus.i_cmd_step  = step;
    bus.i_ready     = 1'b1;
    @(negedge i_clk);
    bus.i_cmd_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    check_val("mid_beat2", {32'd0, bus.o_data}, {32'd0, exp_beat(seed, step, 2)});
    i_rst_n = 1'b0;
    stall_exp = 0;
    #1;
    check_reset_state();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_val("post_rst_cmd_ready", {63'd0, bus.o_cmd_ready}, 64'd1);
    check_val("post_rst_valid", {63'd0, bus.o_valid}, 64'd0);
    send_pkt(1, 32'd7, 32'd1, 0);
  endtask

  initial begin
    int          lens[30];
    logic [31:0] seeds[30];
    logic [31:0] steps[30];
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_len   = '0;
    bus.i_cmd_seed  = '0;
    bus.i_cmd_step  = '0;
    bus.i_ready     = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_state();
    i_rst_n = 1'b1;
    @(negedge i_clk);

    send_pkt(0, 32'h0000_00A5, 32'd1, 0);
    idle_cycles(2);
    send_pkt(3, 32'd10, 32'd5, 0);
    idle_cycles(1);
    send_pkt(3, 32'd10, 32'd5, 1);
    idle_cycles(1);
    send_pkt(2, 32'hFFFF_FFFE, 32'd1, 2);
    idle_cycles(1);
    reset_mid_packet();
    idle_cycles(1);

    // Next command held valid throughout a packet: taken only after the bubble
    nxt_valid = 1'b1;
    nxt_len   = 2;
    nxt_seed  = 32'd100;
    nxt_step  = 32'd3;
    send_pkt(4, 32'd50, 32'd7, 0);
    nxt_valid = 1'b0;
    send_pkt(2, 32'd100, 32'd3, 2);

    // Randomized command stream
    for (int i = 0; i < 30; i++) begin
      lens[i]  = $urandom_range(15, 0);
      seeds[i] = $urandom;
      steps[i] = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
    end
    for (int i = 0; i < 30; i++) begin
      if (i < 29) begin
        nxt_valid = 1'($urandom_range(1, 0));
        nxt_len   = lens[i+1];
        nxt_seed  = seeds[i+1];
        nxt_step  = steps[i+1];
      end else begin
        nxt_valid = 1'b0;
      end
      send_pkt(lens[i], seeds[i], steps[i], 2);
      if (!nxt_valid && ($urandom_range(1, 0) == 1)) idle_cycles($urandom_range(3, 1));
    end

    // Maximum length: 2^NB_LEN beats
    nxt_valid = 1'b0;
    send_pkt(65535, $urandom, $urandom, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axis_pkt_tx.md
Name: axis_pkt_tx

Overview:
AXI-Stream packet transmitter. It accepts a command over a valid/ready port and sources one packet of NB_DATA-bit beats on an AXIS master port. Beats follow an arithmetic sequence, and the last beat is flagged with o_last. The block drives the stream that downstream skid buffers and sinks consume, and is used as a traffic source and test-pattern generator in the datapath.

Parameters:
NB_DATA, 32, data beat width in bits
NB_LEN, 16, width of packet length field (beats minus one)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
o_cmd_ready  output  1  command port ready (registered)
i_cmd_valid  input  1  command port valid
i_cmd_len  input  NB_LEN  packet length minus one (0 = 1 beat)
i_cmd_seed  input  NB_DATA  data value of first beat
i_cmd_step  input  NB_DATA  increment added per beat
i_ready  input  1  downstream ready
o_valid  output  1  stream valid (registered)
o_data  output  NB_DATA  stream data (registered)
o_last  output  1  last beat of packet (registered)
o_busy  output  1  high while a packet is in flight

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - o_valid=0, o_last=0, o_data=0, o_busy=0, o_cmd_ready=1.
  - State=IDLE; internal counter, step and length registers cleared.
- FSM states: IDLE, SEND.
- IDLE:
  - o_cmd_ready=1, o_valid=0.
  - On i_cmd_valid & o_cmd_ready at edge N:
    - latch step; load remaining=i_cmd_len.
    - drive o_data=i_cmd_seed, o_valid=1, o_last=(i_cmd_len==0).
    - o_cmd_ready=0, o_busy=1, go to SEND.
  - First beat is visible at N+1 (one-cycle command-to-data latency).
- SEND, on beat handshake (o_valid & i_ready):
  - If o_last: o_valid=0, o_last=0, o_cmd_ready=1, o_busy=0, go to IDLE.
  - Else: o_data<=o_data+step (modulo 2^NB_DATA, wrap silently); remaining<=remaining-1; o_last<=(remaining==1).
- SEND, no handshake (i_ready=0): o_valid, o_data and o_last hold stable. AXIS rule: o_valid is never deasserted before acceptance.
- i_ready is ignored while o_valid=0. Commands are ignored while o_cmd_ready=0 (no latching, no side effects).
- Throughput: one beat per cycle within a packet. One bubble cycle between packets: last beat accepted at edge M, command accepted at M+1, next first beat valid after M+2.
- i_cmd_len=2^NB_LEN-1 gives 2^NB_LEN beats; the counter must not overflow.
- Reset asserted mid-packet: packet aborts immediately with no o_last; outputs take reset values.
- i_cmd_* fields are sampled only on command handshake; later changes have no effect on the packet in flight.
- No combinational path from any input to any output.

Optional Feature:
- Macro: AXIS_PKT_TX_STALL_CNT_EN.
- Defined:
  - Adds output port o_stall_cnt [31:0].
  - Increments each cycle with o_valid=1 & i_ready=0; saturates at 0xFFFFFFFF.
  - Cleared by reset only.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Cmd len=0, seed=0xA5, step=1, i_ready=1 -> one beat: o_data=0xA5, o_last=1, valid the cycle after the command handshake; o_cmd_ready back to 1 the next cycle.
- Cmd len=3, seed=10, step=5, i_ready=1 -> beats 10, 15, 20, 25 on consecutive cycles; o_last only on 25.
- Same command with i_ready toggling 1,0,0,1,... -> o_data/o_last stable during stalls; same 4 values in order; stall counter (if enabled) equals 2 per stall pair.
- Seed=0xFFFFFFFE, step=1, len=2 -> beats 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; last on 0.
- Reset pulse during beat 2 of a len=7 packet -> o_valid=0 and o_last=0 immediately; after release o_cmd_ready=1, and a new cmd len=1 seed=7 step=1 yields 7, 8.
- Back-to-back commands held valid -> exactly one bubble cycle between the last beat and the next first beat; a command presented during SEND is not consumed until IDLE.
